// File: rtl/hilo_div_ctrl_pkg.sv
// Shared definitions for the HI/LO divider controller.
// Contents: operand/counter widths, DIV/DIVU aluop codes, the double-width
// HI/LO bus type, FSM state encoding and sign helpers.
package hilo_div_ctrl_pkg;

  localparam int unsigned DIV_W        = 32;
  localparam int unsigned CNT_W        = 6;
  localparam int unsigned DIV_ITER     = 32;
  localparam int unsigned DOUBLE_REG_W = 2 * DIV_W;

  localparam logic [7:0] MINIMIPS32_DIV  = 8'h16;
  localparam logic [7:0] MINIMIPS32_DIVU = 8'h17;

  typedef logic [DOUBLE_REG_W-1:0] double_reg_bus_t;

  // HI carries the remainder, LO the quotient.
  typedef struct packed {
    logic [DIV_W-1:0] hi;
    logic [DIV_W-1:0] lo;
  } hilo_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2,
    ST_DIVZ = 2'd3
  } div_state_t;

  // Two's-complement negation when en is set (wraps for the most negative value).
  function automatic logic [DIV_W-1:0] neg_if(input logic [DIV_W-1:0] x, input logic en);
    return en ? (~x + DIV_W'(1)) : x;
  endfunction

  // Magnitude of x when treated as signed; raw value otherwise.
  function automatic logic [DIV_W-1:0] mag_of(input logic [DIV_W-1:0] x, input logic is_signed);
    return neg_if(x, is_signed & x[DIV_W-1]);
  endfunction

endpackage

// File: rtl/hilo_div_ctrl_div_core.sv
// Restoring divider datapath: operand/partial-remainder registers, one
// shift/subtract step per enabled cycle, and sign correction of the result.
// Ports:
//   clk, rst        clock, async active-high reset
//   load            capture operand magnitudes and sign flags, clear remainder
//   step            perform one restoring iteration
//   signed_op       1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1/opdata2 dividend / divisor
//   result_c        sign-corrected {rem, quo} as they will be after this step
module hilo_div_ctrl_div_core
  import hilo_div_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
  input  logic                    signed_op,
  input  logic [DIV_W-1:0]        opdata1,
  input  logic [DIV_W-1:0]        opdata2,
  output logic [DOUBLE_REG_W-1:0] result_c
);

  logic [DIV_W-1:0] dvd_q;   // dividend bits shift out the top, quotient bits in the bottom
  logic [DIV_W-1:0] dsr_q;
  logic [DIV_W-1:0] rem_q;
  logic             q_neg_q;
  logic             r_neg_q;

  logic [DIV_W:0]   rem_sh;
  logic [DIV_W-1:0] diff;
  logic             ge;
  logic [DIV_W-1:0] rem_nx;
  logic [DIV_W-1:0] dvd_nx;
  hilo_t            res;

  // One restoring step; the shifted remainder needs one extra bit before the compare.
  always_comb begin
    rem_sh = {rem_q, dvd_q[DIV_W-1]};
    ge     = (rem_sh >= {1'b0, dsr_q});
    diff   = rem_sh[DIV_W-1:0] - dsr_q;
    rem_nx = ge ? diff : rem_sh[DIV_W-1:0];
    dvd_nx = {dvd_q[DIV_W-2:0], ge};
    res.hi = neg_if(rem_nx, r_neg_q);
    res.lo = neg_if(dvd_nx, q_neg_q);
  end

  assign result_c = res;

  // Operand capture and iteration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (load) begin
      dvd_q   <= mag_of(opdata1, signed_op);
      dsr_q   <= mag_of(opdata2, signed_op);
      rem_q   <= '0;
      q_neg_q <= signed_op & (opdata1[DIV_W-1] ^ opdata2[DIV_W-1]);
      r_neg_q <= signed_op & opdata1[DIV_W-1];
    end else if (step) begin
      dvd_q   <= dvd_nx;
      rem_q   <= rem_nx;
    end
  end

endmodule

// File: rtl/hilo_div_ctrl.sv
// Multi-cycle DIV/DIVU controller for the HI/LO writeback path: sequences a
// 32-step restoring divide, requests a pipeline stall until the result is
// ready, and presents {remainder, quotient} for the HI/LO write.
// Optional feature macro: HILO_DIV_ZERO_FAST_EN -- a zero divisor skips the
// iterations and answers {dividend, all-ones} one cycle after start.
// Ports:
//   cpu_clk_50M, cpu_rst   clock, async active-high reset
//   div_start_i            EX holds a valid DIV/DIVU
//   div_signed_i           1 = DIV, 0 = DIVU
//   div_opdata1_i/2_i      dividend / divisor
//   div_annul_i            flush/exception, aborts the divide
//   stall_i                pipeline held by another source
//   div_ready_o            result valid (HI/LO write enable)
//   div_result_o           {remainder, quotient}
//   stall_req_o            divider stall request
//   div_busy_o             controller not idle
module hilo_div_ctrl
  import hilo_div_ctrl_pkg::*;
(
  input  logic                 cpu_clk_50M,
  input  logic                 cpu_rst,
  input  logic                 div_start_i,
  input  logic                 div_signed_i,
  input  logic [DIV_W-1:0]     div_opdata1_i,
  input  logic [DIV_W-1:0]     div_opdata2_i,
  input  logic                 div_annul_i,
  input  logic                 stall_i,
  output logic                 div_ready_o,
  output logic [2*DIV_W-1:0]   div_result_o,
  output logic                 stall_req_o,
  output logic                 div_busy_o
);

  div_state_t              state;
  logic [CNT_W-1:0]        cnt;
  logic                    core_load;
  logic                    core_step;
  logic [DOUBLE_REG_W-1:0] core_res_c;

  assign core_load   = (state == ST_IDLE) & div_start_i & ~div_annul_i;
  assign core_step   = (state == ST_DIV) & ~div_annul_i;
  assign stall_req_o = div_start_i & ~div_ready_o & ~div_annul_i;
  assign div_busy_o  = (state != ST_IDLE);

  hilo_div_ctrl_div_core u_core (
    .clk       (cpu_clk_50M),
    .rst       (cpu_rst),
    .load      (core_load),
    .step      (core_step),
    .signed_op (div_signed_i),
    .opdata1   (div_opdata1_i),
    .opdata2   (div_opdata2_i),
    .result_c  (core_res_c)
  );

  // Control FSM; annul wins over start and over completion.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      div_ready_o  <= 1'b0;
      div_result_o <= '0;
    end else if (div_annul_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      div_ready_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          div_ready_o <= 1'b0;
          if (div_start_i) begin
`ifdef HILO_DIV_ZERO_FAST_EN
            if (div_opdata2_i == '0) begin
              state        <= ST_DIVZ;
              div_ready_o  <= 1'b1;
              div_result_o <= {div_opdata1_i, {DIV_W{1'b1}}};
            end else
`endif
            begin
              state <= ST_DIV;
              cnt   <= '0;
            end
          end
        end
        ST_DIV: begin
          cnt <= cnt + CNT_W'(1);
          // Last step: capture the corrected result straight from the step logic.
          if (cnt == CNT_W'(DIV_ITER - 1)) begin
            state        <= ST_DONE;
            div_ready_o  <= 1'b1;
            div_result_o <= core_res_c;
          end
        end
        ST_DONE: begin
          if (!stall_i) begin
            state       <= ST_IDLE;
            div_ready_o <= 1'b0;
          end
        end
        ST_DIVZ: begin
          // Ready already shown this cycle; only linger in DONE if the pipe is held.
          if (stall_i) begin
            state <= ST_DONE;
          end else begin
            state       <= ST_IDLE;
            div_ready_o <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl: directed divides with literal
// expectations plus a cycle-level reference model compared every cycle.
module tb_hilo_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_start = 1'b0;
  logic        div_signed = 1'b0;
  logic [31:0] div_op1 = '0;
  logic [31:0] div_op2 = '0;
  logic        div_annul = 1'b0;
  logic        stall = 1'b0;
  logic        div_ready;
  logic [63:0] div_result;
  logic        stall_req;
  logic        div_busy;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

`ifdef HILO_DIV_ZERO_FAST_EN
  localparam bit FAST_Z = 1'b1;
`else
  localparam bit FAST_Z = 1'b0;
`endif

  hilo_div_ctrl dut (
    .cpu_clk_50M   (clk),
    .cpu_rst       (rst),
    .div_start_i   (div_start),
    .div_signed_i  (div_signed),
    .div_opdata1_i (div_op1),
    .div_opdata2_i (div_op2),
    .div_annul_i   (div_annul),
    .stall_i       (stall),
    .div_ready_o   (div_ready),
    .div_result_o  (div_result),
    .stall_req_o   (stall_req),
    .div_busy_o    (div_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference quotient/remainder from plain 64-bit arithmetic on magnitudes.
  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint unsigned ma, mb, q, r;
    logic [31:0] q32, r32;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    ma  = (s && a[31]) ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
    mb  = (s && b[31]) ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
    q   = ma / mb;
    r   = ma % mb;
    q32 = q[31:0];
    r32 = r[31:0];
    if (s && (a[31] ^ b[31])) q32 = 32'd0 - q32;
    if (s && a[31])           r32 = 32'd0 - r32;
    return {r32, q32};
  endfunction

  // Cycle model: a job needs 32 edges of work after the start edge, then ready
  // stays up until a cycle with stall low; annul drops everything.
  bit          m_run = 1'b0;
  bit          m_ready = 1'b0;
  int          m_left = 0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_result = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 1'b0; m_ready = 1'b0; m_left = 0; m_result = '0;
    end else if (div_annul) begin
      m_run = 1'b0; m_ready = 1'b0;
    end else if (m_ready) begin
      if (!stall) m_ready = 1'b0;
    end else if (m_run) begin
      m_left--;
      if (m_left == 0) begin
        m_run = 1'b0; m_ready = 1'b1; m_result = m_pend;
      end
    end else if (div_start) begin
      m_pend = model_div(div_op1, div_op2, div_signed);
      if (FAST_Z && div_op2 == 32'd0) begin
        m_ready = 1'b1; m_result = m_pend;
      end else begin
        m_run = 1'b1; m_left = 32;
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("cyc_ready", {63'd0, div_ready}, {63'd0, m_ready});
      chk("cyc_busy", {63'd0, div_busy}, {63'd0, m_run | m_ready});
      chk("cyc_stall_req", {63'd0, stall_req}, {63'd0, div_start & ~m_ready & ~div_annul});
      chk("cyc_result", div_result, m_result);
    end
  end

  // Issue a divide at the current cycle, wait for ready, check latency and value.
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp_res, input int exp_lat);
    int k;
    bit seen;
    div_op1 = a; div_op2 = b; div_signed = s; div_start = 1'b1;
    k = 0; seen = 1'b0;
    while (k < 100 && !seen) begin
      @(posedge clk); #1;
      k++;
      seen = div_ready;
    end
    chk({name, "_latency"}, 64'(k), 64'(exp_lat));
    chk({name, "_result"}, div_result, exp_res);
    @(posedge clk); #1;
    div_start = 1'b0;
    chk({name, "_idle_after"}, {63'd0, div_busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

  initial begin
    int nrdy;
    logic [63:0] held;
    #1;
    chk("rst_ready", {63'd0, div_ready}, 64'd0);
    chk("rst_result", div_result, 64'd0);
    chk("rst_busy", {63'd0, div_busy}, 64'd0);
    chk("rst_stall_req", {63'd0, stall_req}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    run_div("divu_100_7", 32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, 33);
    run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, 33);
    run_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
    run_div("div_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'h0000_000E}, 33);
    run_div("divu_big", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0000_0000}, 33);
    run_div("divu_small", 32'd5, 32'd9, 1'b0, {32'h0000_0005, 32'h0000_0000}, 33);
    run_div("divu_by1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'h0000_0000, 32'hFFFF_FFFF}, 33);
    run_div("divu_zero", 32'h0000_1234, 32'd0, 1'b0, {32'h0000_1234, 32'hFFFF_FFFF}, FAST_Z ? 1 : 33);

    // Annul at N+10: idle at N+11, restart at N+12 completes at N+45.
    div_op1 = 32'd1000; div_op2 = 32'd3; div_signed = 1'b0; div_start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    div_annul = 1'b1;
    #1;
    chk("annul_stall_req", {63'd0, stall_req}, 64'd0);
    chk("annul_busy_before", {63'd0, div_busy}, 64'd1);
    @(posedge clk); #1;
    div_annul = 1'b0; div_start = 1'b0;
    chk("annul_busy_after", {63'd0, div_busy}, 64'd0);
    chk("annul_ready_after", {63'd0, div_ready}, 64'd0);
    @(posedge clk); #1;
    run_div("post_annul", 32'd1000, 32'd3, 1'b0, {32'h0000_0001, 32'h0000_014D}, 33);

    // Stall held 3 cycles in DONE with start still high: ready for 4 cycles, no restart.
    div_op1 = 32'hDEAD_BEEF; div_op2 = 32'h10; div_signed = 1'b0; div_start = 1'b1;
    nrdy = 0;
    while (nrdy < 100 && !div_ready) begin @(posedge clk); #1; nrdy++; end
    chk("stall_latency", 64'(nrdy), 64'd33);
    stall = 1'b1;
    held = div_result;
    chk("stall_result", held, {32'h0000_000F, 32'h0DEA_DBEE});
    nrdy = 1;
    repeat (3) begin
      @(posedge clk); #1;
      if (div_ready) nrdy++;
      chk("stall_result_hold", div_result, held);
    end
    stall = 1'b0;
    @(posedge clk); #1;
    div_start = 1'b0;
    chk("stall_ready_cycles", 64'(nrdy), 64'd4);
    chk("stall_no_restart", {63'd0, div_busy}, 64'd0);
    @(posedge clk); #1;

    // Async reset mid-divide at N+15.
    div_op1 = 32'h1234_5678; div_op2 = 32'd9; div_signed = 1'b0; div_start = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1; div_start = 1'b0;
    #1;
    chk("arst_ready", {63'd0, div_ready}, 64'd0);
    chk("arst_result", div_result, 64'd0);
    chk("arst_busy", {63'd0, div_busy}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_still_idle", {63'd0, div_busy}, 64'd0);
    run_div("post_arst", 32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, 33);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- Multi-cycle divider controller feeding the HI/LO writeback path of the MiniMIPS32 pipeline.
- Accepts DIV/DIVU from the execute stage and sequences a 32-iteration restoring divider.
- Holds a pipeline stall request until the result is ready.
- Presents the 64-bit {remainder, quotient} result for the HI/LO write (hi = remainder, lo = quotient).

Parameters:
- DIV_W, 32, operand width in bits; also the iteration count.
- CNT_W, 6, width of the iteration counter.

Ports:
- cpu_clk_50M  in  1  core clock; all state updates on the rising edge.
- cpu_rst  in  1  reset, asynchronous, active-high.
- div_start_i  in  1  EX stage holds a valid DIV/DIVU.
- div_signed_i  in  1  1 = DIV, 0 = DIVU.
- div_opdata1_i  in  DIV_W  dividend.
- div_opdata2_i  in  DIV_W  divisor.
- div_annul_i  in  1  flush or exception; abort the current divide.
- stall_i  in  1  pipeline held by another source this cycle.
- div_ready_o  out  1  result valid; drives the HI/LO write enable.
- div_result_o  out  2*DIV_W  {remainder, quotient}.
- stall_req_o  out  1  divider stall request to the stall controller.
- div_busy_o  out  1  state is not IDLE.

Behaviour:
- States: IDLE, DIV, DONE, plus DIVZ when the optional feature is compiled in.
- Reset (async, any state) clears everything: state = IDLE, counter = 0, div_ready_o = 0, div_result_o = 0, internal registers = 0.
- IDLE, div_start_i = 1, div_annul_i = 0 at cycle N:
  - Latch operand magnitudes: absolute value when div_signed_i = 1, raw value otherwise.
  - Latch the sign flags: quotient sign = sign1 XOR sign2; remainder sign = sign1.
  - Clear the partial remainder and counter; go to DIV.
- DIV: one restoring step per cycle.
  - Shift {rem, dividend} left by 1.
  - If rem >= divisor: subtract the divisor and set quotient bit = 1; else quotient bit = 0.
  - Counter increments each step; after the 32nd step (cycle N+32), go to DONE.
- DONE (cycle N+33):
  - div_result_o = sign-corrected {rem, quo}, using two's-complement negation where the latched sign flag = 1.
  - div_ready_o = 1.
  - Stay in DONE while stall_i = 1; div_ready_o and div_result_o stay stable.
  - Go to IDLE on the first cycle with stall_i = 0. The same EX instruction therefore never restarts.
- stall_req_o = div_start_i & ~div_ready_o & ~div_annul_i (combinational). It is high for cycles N..N+32 and low at N+33.
- div_annul_i = 1 in any state: go to IDLE next cycle, div_ready_o = 0, no result is presented. Annul has priority over start and over completion in the same cycle.
- div_busy_o = (state != IDLE).
- Outside DONE: div_ready_o = 0 and div_result_o holds its last value.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): result = {0x00000000, 0x80000000}, which falls out of wrap-around negation.

Optional Feature:
- Macro: HILO_DIV_ZERO_FAST_EN.
- Defined: divisor = 0 at start goes IDLE -> DIVZ -> DONE. div_ready_o is asserted at cycle N+1 with result {div_opdata1_i, 32'hFFFFFFFF}, with no sign correction applied.
- Undefined: divisor = 0 runs the full 32 iterations.
  - Unsigned result is {dividend, 32'hFFFFFFFF} at N+33.
  - Signed result is the algorithm output after sign correction. It is architecturally undefined and not checked.

Decomposition:
- Shared defines: MINIMIPS32_DIV/DIVU aluop codes, DOUBLE_REG_BUS, the state encoding (2-bit: IDLE = 0, DIV = 1, DONE = 2, DIVZ = 3), and DIV_ITER = 32.
- Sub-module div_core: operand registers, shift/subtract step and sign correction.
- hilo_div_ctrl itself keeps the FSM, counter, handshake and stall logic.

Test Plan:
- DIVU 100 / 7, start at N -> stall_req_o high for N..N+32; div_ready_o = 1 at N+33; result {0x00000002, 0x0000000E}.
- DIV -7 / 2 -> result {0xFFFFFFFF, 0xFFFFFFFD}. DIV 0x80000000 / 0xFFFFFFFF -> result {0x00000000, 0x80000000}.
- Annul at N+10 -> IDLE at N+11; div_ready_o never asserts; stall_req_o low from N+10. A new start at N+12 then completes at N+45.
- stall_i = 1 for 3 cycles on reaching DONE -> div_ready_o and div_result_o stable for 4 cycles, then IDLE. No restart while div_start_i stays high during those cycles.
- DIVU 0x1234 / 0 -> with HILO_DIV_ZERO_FAST_EN: ready at N+1, result {0x00001234, 0xFFFFFFFF}. Without it: same value at N+33.
- cpu_rst pulsed mid-DIV at N+15 (asynchronous, between edges) -> outputs 0 immediately; state IDLE; the next start behaves normally.
